// File: rtl/traffic_phase_scheduler_if.sv
// rtl/traffic_phase_scheduler_if.sv - sensor/preemption inputs and lamp/status outputs of the phase scheduler
interface traffic_phase_scheduler_if;
  logic        tick;
  logic [3:0]  sensor;
  logic        preempt_valid;
  logic [1:0]  preempt_phase;
  logic [11:0] lights;
  logic [1:0]  cur_phase;
  logic [1:0]  state;
  logic        green_start;

  modport master (
    output tick, sensor, preempt_valid, preempt_phase,
    input  lights, cur_phase, state, green_start
  );

  modport slave (
    input  tick, sensor, preempt_valid, preempt_phase,
    output lights, cur_phase, state, green_start
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - four-approach round-robin signal sequencer with min/max green and preemption
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int TIMER_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  traffic_phase_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_e;

  localparam logic [2:0]         LAMP_RED    = 3'b100;
  localparam logic [2:0]         LAMP_YELLOW = 3'b010;
  localparam logic [2:0]         LAMP_GREEN  = 3'b001;
  localparam logic [TIMER_W-1:0] T_MIN       = TIMER_W'(GREEN_MIN);
  localparam logic [TIMER_W-1:0] T_MAX       = TIMER_W'(GREEN_MAX);
  localparam logic [TIMER_W-1:0] T_YEL_LAST  = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] T_AR_LAST   = TIMER_W'(ALLRED_T - 1);
  localparam logic [TIMER_W-1:0] T_ONE       = TIMER_W'(1);

  state_e             state_q, state_d;
  logic [1:0]         cur_phase_q, cur_phase_d;
  logic [1:0]         nxt_q, nxt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         pending_q, pending_d;
  logic [11:0]        lights_q, lights_d;
  logic               green_start_q, green_start_d;

  logic [3:0] cur_onehot;
  logic [3:0] others;
  logic [3:0] set_mask;
  logic       other_pending;
  logic       preempt_other;
  logic       preempt_hold;
  logic       yield;
  logic [1:0] rr_pick;
  logic [1:0] rr_idx;

  assign cur_onehot    = 4'b0001 << cur_phase_q;
  assign others        = pending_q & ~cur_onehot;
  assign other_pending = |others;
  assign preempt_other = bus.preempt_valid && (bus.preempt_phase != cur_phase_q);
  assign preempt_hold  = bus.preempt_valid && (bus.preempt_phase == cur_phase_q);
  assign yield = other_pending && !preempt_hold && (timer_q >= T_MIN) &&
                 (!bus.sensor[cur_phase_q] || (timer_q >= T_MAX));

  // Walk downward so the closest phase after cur_phase is the one that sticks.
  always_comb begin
    rr_pick = cur_phase_q;
    rr_idx  = '0;
    for (int k = 3; k >= 1; k--) begin
      rr_idx = cur_phase_q + 2'(k);
      if (others[rr_idx]) rr_pick = rr_idx;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_phase_d   = cur_phase_q;
    nxt_d         = nxt_q;
    timer_d       = timer_q;
    green_start_d = 1'b0;
    set_mask      = bus.sensor & ~(4'b0001 << nxt_q);
    if (state_q == ST_GREEN) set_mask = set_mask | (bus.sensor & ~cur_onehot);
    pending_d     = pending_q | set_mask;

    case (state_q)
      ST_GREEN: begin
        if (bus.tick && (timer_q < T_MAX)) timer_d = timer_q + T_ONE;
        if (preempt_other) begin
          nxt_d   = bus.preempt_phase;
          state_d = ST_YELLOW;
          timer_d = '0;
        end else if (yield) begin
          nxt_d   = rr_pick;
          state_d = ST_YELLOW;
          timer_d = '0;
        end
      end
      ST_YELLOW: begin
        if (bus.preempt_valid) nxt_d = bus.preempt_phase;
        if (bus.tick) begin
          if (timer_q == T_YEL_LAST) begin
            state_d = ST_ALLRED;
            timer_d = '0;
          end else begin
            timer_d = timer_q + T_ONE;
          end
        end
      end
      ST_ALLRED: begin
        if (bus.preempt_valid) nxt_d = bus.preempt_phase;
        if (bus.tick) begin
          if (timer_q == T_AR_LAST) begin
            state_d       = ST_GREEN;
            timer_d       = '0;
            cur_phase_d   = nxt_d;
            green_start_d = 1'b1;
            pending_d     = pending_d & ~(4'b0001 << nxt_d);
          end else begin
            timer_d = timer_q + T_ONE;
          end
        end
      end
      default: begin
        state_d = ST_GREEN;
        timer_d = '0;
      end
    endcase

    // Lamps follow the next state so they change together with state_q.
    lights_d = {4{LAMP_RED}};
    for (int i = 0; i < 4; i++) begin
      if (cur_phase_d == 2'(i)) begin
        if (state_d == ST_GREEN)       lights_d[3*i +: 3] = LAMP_GREEN;
        else if (state_d == ST_YELLOW) lights_d[3*i +: 3] = LAMP_YELLOW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_GREEN;
      cur_phase_q   <= 2'd0;
      nxt_q         <= 2'd0;
      timer_q       <= '0;
      pending_q     <= 4'd0;
      lights_q      <= 12'b100_100_100_001;
      green_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_phase_q   <= cur_phase_d;
      nxt_q         <= nxt_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      lights_q      <= lights_d;
      green_start_q <= green_start_d;
    end
  end

  assign bus.lights      = lights_q;
  assign bus.cur_phase   = cur_phase_q;
  assign bus.state       = state_q;
  assign bus.green_start = green_start_q;

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Sequences one signalised intersection of 4 approaches (phase 0 = highway, phases 1-3 = farm road and side approaches).
- Collects sticky service requests from approach sensors and grants green round-robin, with min/max green, fixed yellow and all-red clearance.
- Supports emergency preemption.
- Drives the per-approach 3-bit lamp codes that feed the existing light drivers.

Parameters:
- GREEN_MIN, 4, minimum green duration in ticks before a phase may yield
- GREEN_MAX, 16, maximum green duration in ticks while the current phase's own sensor stays asserted
- YELLOW_T, 3, yellow duration in ticks (≥1)
- ALLRED_T, 2, all-red clearance duration in ticks (≥1)
- TIMER_W, 5, tick-timer width; must hold GREEN_MAX

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- tick  in  1  one-cycle timebase pulse; all durations count tick cycles
- sensor  in  4  per-phase vehicle sensors, level; bit i = phase i
- preempt_valid  in  1  emergency preemption active (level)
- preempt_phase  in  2  phase to serve under preemption
- lights  out  12  lamp codes; bits [3i+2:3i] = phase i; RED=3'b100, YELLOW=3'b010, GREEN=3'b001
- cur_phase  out  2  phase currently holding or last holding green
- state  out  2  0=GREEN, 1=YELLOW, 2=ALLRED
- green_start  out  1  one-cycle pulse on the first cycle of every new green

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state=GREEN, cur_phase=0, lights=12'b100_100_100_001, green_start=0, timer=0, pending=0, nxt=0.
- Reset mid-operation returns immediately to these values with no yellow/all-red sequence.
- All outputs are registered. Lamp changes appear the cycle after the decision.
- Pending:
  - pending[i] is set when sensor[i]=1, for every i ≠ cur_phase while in GREEN.
  - pending[i] is set in any state when i ≠ nxt.
  - pending[nxt] is cleared on entry to GREEN.
  - Set and clear in the same cycle: clear wins only for the phase entering green.
- GREEN:
  - lights: cur_phase GREEN, all others RED.
  - timer += 1 on tick, saturating at GREEN_MAX.
  - Let other = |(pending & ~(1<<cur_phase)).
  - Yield when other && timer ≥ GREEN_MIN && (!sensor[cur_phase] || timer ≥ GREEN_MAX).
  - With no other pending, green rests indefinitely on the current phase.
  - On yield: nxt = first pending phase searching cur_phase+1, +2, +3 (mod 4); state→YELLOW; timer→0.
- YELLOW: cur_phase YELLOW, others RED. On tick: if timer==YELLOW_T-1 then state→ALLRED, timer→0; else timer += 1. Yellow therefore spans exactly YELLOW_T ticks.
- ALLRED: all RED. Same counting with ALLRED_T. On exit: state→GREEN, cur_phase←nxt, timer←0, green_start=1 for one cycle.
- Preemption, evaluated every cycle (no tick required):
  - GREEN, preempt_phase ≠ cur_phase: yield next cycle regardless of GREEN_MIN; nxt←preempt_phase.
  - GREEN, preempt_phase == cur_phase: never yield while preempt_valid=1; timer keeps saturating.
  - YELLOW/ALLRED: nxt←preempt_phase. The clearance sequence is never shortened.
  - Preemption deasserted mid-sequence: the sequence completes to the already-chosen nxt.
- Simultaneous yield condition and preemption: preemption target wins.
- No pending phases other than the current one: the round-robin search is not evaluated.
- Invariant: at most one phase is non-RED in any cycle. The bench checks this every cycle.

Test Plan:
- Reset, tick=1 constantly, sensor=0 → lights=12'b100_100_100_001 held for 50 cycles; green_start never pulses.
- sensor[2] pulsed 1 cycle after reset, tick=1 → phase0 GREEN 4 cycles; YELLOW 3 cycles; all-RED 2 cycles; then lights=12'b100_001_100_100, cur_phase=2, green_start pulses once; pending[2] cleared.
- sensor[0] held high + sensor[1] pulse → phase0 stays GREEN until timer=16, then YELLOW; phase1 green after 3+2 ticks.
- sensor=4'b1110 pulsed while phase0 green → service order 1,2,3, then rest on phase3; each green exactly GREEN_MIN ticks.
- preempt_valid=1, preempt_phase=3 at timer=1 of phase0 green → YELLOW next cycle; phase3 green after full 3+2; pending[1] set during the sequence is served afterward.
- rst_n low during YELLOW (async, mid-cycle) → outputs return to reset values immediately, before the next clk edge.
